// File: rtl/serie_paralelo_align.sv
// serie_paralelo_align: bit-serial to WIDTH-bit parallel deserializer for the
// PHY receive path. It hunts for COMMA at any bit offset, verifies alignment
// over LOCK_COUNT consecutive commas and then emits one strobe per data word.
// Optional build macro: LOS_DETECT_EN. When defined, LOCKED is dropped after
// MAX_GAP word boundaries without a comma.
//
// Output handshake: valid_out is a one-cycle strobe with no back-pressure.
// data_out is meaningful in the cycle valid_out is high and holds its value
// until the next strobe; the consumer must take it in that cycle.
module serie_paralelo_align #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = 'hBC,
  parameter int               LOCK_COUNT = 4,
  parameter int               MAX_GAP    = 32
) (
  input  logic             clk_8f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active,
  output logic             comma_seen,
  output logic [3:0]       comma_count,
  output logic [1:0]       fsm_state_o
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0]    LOCK_CNT = 4'(LOCK_COUNT);

  // Reject parameter sets the counters cannot represent.
  if (WIDTH < 4 || LOCK_COUNT < 1 || LOCK_COUNT > 15 ||
      MAX_GAP < 1 || MAX_GAP > 63) begin : g_param_check
    $error("serie_paralelo_align: parameter out of range");
  end

  logic [WIDTH-1:0] sr_q, sr_d, next_sr;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             seen_q, seen_d;
  logic             boundary, is_comma;
`ifdef LOS_DETECT_EN
  localparam logic [5:0] GAP_MAX = 6'(MAX_GAP);
  logic [5:0]       gap_q, gap_d;
`endif

  // Next-state logic: shift, word framing and the HUNT/VERIFY/LOCKED machine.
  always_comb begin
    next_sr   = {sr_q[WIDTH-2:0], data_in};
    sr_d      = next_sr;
    boundary  = (bit_cnt_q == LAST_BIT);
    is_comma  = (next_sr == COMMA);
    state_d   = state_q;
    bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    seen_d    = 1'b0;
`ifdef LOS_DETECT_EN
    gap_d     = gap_q;
`endif
    case (state_q)
      HUNT: begin
        // Any-offset search; the matching comma fixes the word phase and
        // counts as the first aligned comma.
        bit_cnt_d = '0;
        if (is_comma) begin
          cnt_d   = 4'd1;
          seen_d  = 1'b1;
          state_d = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
`ifdef LOS_DETECT_EN
          gap_d   = 6'd0;
`endif
        end
      end
      VERIFY: begin
        if (boundary) begin
          if (is_comma) begin
            cnt_d  = cnt_q + 4'd1;
            seen_d = 1'b1;
            if (cnt_q + 4'd1 >= LOCK_CNT) begin
              state_d = LOCKED;
`ifdef LOS_DETECT_EN
              gap_d   = 6'd0;
`endif
            end
          end else begin
            // Misaligned guess: restart the search on the following edge.
            state_d = HUNT;
            cnt_d   = 4'd0;
          end
        end
      end
      LOCKED: begin
        // Alignment is frozen here; comma patterns straddling words are
        // just data bits.
        if (boundary) begin
          if (is_comma) begin
            seen_d = 1'b1;
`ifdef LOS_DETECT_EN
            gap_d  = 6'd0;
`endif
          end else begin
`ifdef LOS_DETECT_EN
            gap_d = gap_q + 6'd1;
            if (gap_d == GAP_MAX) begin
              state_d = HUNT;
              cnt_d   = 4'd0;
            end else begin
              valid_d = 1'b1;
              data_d  = next_sr;
            end
`else
            valid_d = 1'b1;
            data_d  = next_sr;
`endif
          end
        end
      end
      default: begin
        state_d = HUNT;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State registers; asynchronous active-low reset discards any partial word.
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
      state_q   <= HUNT;
      cnt_q     <= 4'd0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      seen_q    <= 1'b0;
`ifdef LOS_DETECT_EN
      gap_q     <= 6'd0;
`endif
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      seen_q    <= seen_d;
`ifdef LOS_DETECT_EN
      gap_q     <= gap_d;
`endif
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign comma_seen  = seen_q;
  assign comma_count = cnt_q;
  assign active      = (state_q == LOCKED);
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_serie_paralelo_align.sv
// Directed bench for serie_paralelo_align (WIDTH=8, COMMA=BC, LOCK_COUNT=4,
// MAX_GAP=4). Inputs change on the falling edge, outputs are sampled on the
// next falling edge so each sample reflects exactly one rising edge.
module tb_serie_paralelo_align;

  logic       clk_8f = 1'b0;
  logic       reset  = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       comma_seen;
  logic [3:0] comma_count;
  logic [1:0] fsm_state_o;

  localparam logic [1:0] ST_HUNT = 2'd0;

  int n_vec = 0;
  int n_err = 0;

  // Observation accumulators, cleared per scenario.
  int         n_valid;
  int         n_seen;
  int         n_both;
  logic [7:0] got_q[$];
  logic [3:0] cc_q[$];

  serie_paralelo_align #(
    .WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(4), .MAX_GAP(4)
  ) dut (
    .clk_8f(clk_8f), .reset(reset), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .active(active),
    .comma_seen(comma_seen), .comma_count(comma_count),
    .fsm_state_o(fsm_state_o)
  );

  // Clock
  always #5 clk_8f = ~clk_8f;

  task automatic clear_obs();
    n_valid = 0;
    n_seen  = 0;
    n_both  = 0;
    got_q.delete();
    cc_q.delete();
  endtask

  // Driver: one bit per clock, then record what the edge produced.
  task automatic send_bit(input logic b);
    data_in = b;
    @(negedge clk_8f);
    if (valid_out === 1'b1) begin
      n_valid++;
      got_q.push_back(data_out);
    end
    if (comma_seen === 1'b1) begin
      n_seen++;
      cc_q.push_back(comma_count);
    end
    if (valid_out === 1'b1 && comma_seen === 1'b1) n_both++;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    repeat (cycles) @(negedge clk_8f);
    reset = 1'b1;
    clear_obs();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk_8f);
    n_vec++;
    if ({data_out, valid_out, active, comma_seen, comma_count} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got data=%h v=%b act=%b seen=%b cc=%0d, want all 0",
               data_out, valid_out, active, comma_seen, comma_count);
    end
    n_vec++;
    if (fsm_state_o !== ST_HUNT) begin
      n_err++;
      $display("FAIL reset_state: got %0d want %0d", fsm_state_o, ST_HUNT);
    end
    reset = 1'b1;
    clear_obs();
  endtask

  task automatic test_aligned_lock();
    repeat (3) send_word(8'hBC);
    n_vec++;
    if (active !== 1'b0) begin
      n_err++;
      $display("FAIL t1_active_after_3: got %b want 0", active);
    end
    send_word(8'hBC);
    n_vec++;
    if (active !== 1'b1) begin
      n_err++;
      $display("FAIL t1_active_after_4: got %b want 1", active);
    end
    n_vec++;
    if (n_seen !== 4) begin
      n_err++;
      $display("FAIL t1_comma_pulses: got %0d want 4", n_seen);
    end
    for (int i = 0; i < cc_q.size() && i < 4; i++) begin
      n_vec++;
      if (cc_q[i] !== 4'(i + 1)) begin
        n_err++;
        $display("FAIL t1_comma_count[%0d]: got %0d want %0d", i, cc_q[i], i + 1);
      end
    end
    send_word(8'h55);
    n_vec++;
    if (valid_out !== 1'b1 || data_out !== 8'h55) begin
      n_err++;
      $display("FAIL t1_data: got v=%b data=%h want v=1 data=55", valid_out, data_out);
    end
    send_bit(1'b0);
    n_vec++;
    if (valid_out !== 1'b0 || n_valid !== 1) begin
      n_err++;
      $display("FAIL t1_single_pulse: got v=%b pulses=%0d want v=0 pulses=1",
               valid_out, n_valid);
    end
  endtask

  task automatic test_offset_lock();
    logic [2:0] pre;
    do_reset(2);
    pre = 3'($urandom_range(0, 7));
    for (int i = 2; i >= 0; i--) send_bit(pre[i]);
    repeat (4) send_word(8'hBC);
    n_vec++;
    if (active !== 1'b1) begin
      n_err++;
      $display("FAIL t2_active: got %b want 1 (prefix %b)", active, pre);
    end
    for (int i = 7; i >= 1; i--) send_bit(1'(8'hA7 >> i));
    n_vec++;
    if (n_valid !== 0) begin
      n_err++;
      $display("FAIL t2_early_valid: got %0d pulses before bit 8, want 0", n_valid);
    end
    send_bit(1'b1);
    n_vec++;
    if (valid_out !== 1'b1 || data_out !== 8'hA7 || n_valid !== 1) begin
      n_err++;
      $display("FAIL t2_data: got v=%b data=%h pulses=%0d want v=1 data=a7 pulses=1",
               valid_out, data_out, n_valid);
    end
  endtask

  task automatic test_relock();
    do_reset(2);
    send_word(8'hBC);
    send_word(8'hBC);
    n_vec++;
    if (comma_count !== 4'd2) begin
      n_err++;
      $display("FAIL t3_count_before_break: got %0d want 2", comma_count);
    end
    send_word(8'h3C);
    n_vec++;
    if (comma_count !== 4'd0 || fsm_state_o !== ST_HUNT || active !== 1'b0) begin
      n_err++;
      $display("FAIL t3_back_to_hunt: got cc=%0d st=%0d act=%b want cc=0 st=0 act=0",
               comma_count, fsm_state_o, active);
    end
    repeat (3) send_word(8'hBC);
    n_vec++;
    if (active !== 1'b0) begin
      n_err++;
      $display("FAIL t3_early_lock: got active=%b want 0", active);
    end
    send_word(8'hBC);
    n_vec++;
    if (active !== 1'b1) begin
      n_err++;
      $display("FAIL t3_relock: got active=%b want 1", active);
    end
    send_word(8'h11);
    n_vec++;
    if (n_valid !== 1 || got_q.size() < 1 || got_q[0] !== 8'h11) begin
      n_err++;
      $display("FAIL t3_only_output: got pulses=%0d first=%h want pulses=1 first=11",
               n_valid, (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
  endtask

  task automatic test_locked_stream();
    logic [7:0] exp_q[$];
    exp_q = '{8'h12, 8'h34, 8'h0B, 8'hC0};
    clear_obs();
    send_word(8'h12);
    n_vec++;
    if (valid_out !== 1'b1 || data_out !== 8'h12) begin
      n_err++;
      $display("FAIL t4_word12: got v=%b data=%h want v=1 data=12", valid_out, data_out);
    end
    send_word(8'hBC);
    n_vec++;
    if (comma_seen !== 1'b1 || valid_out !== 1'b0 || data_out !== 8'h12) begin
      n_err++;
      $display("FAIL t4_comma_hold: got seen=%b v=%b data=%h want seen=1 v=0 data=12",
               comma_seen, valid_out, data_out);
    end
    send_word(8'h34);
    // 0B,C0 carry a BC pattern across the word boundary.
    send_word(8'h0B);
    send_word(8'hC0);
    n_vec++;
    if (n_seen !== 1 || n_both !== 0) begin
      n_err++;
      $display("FAIL t4_comma_pulses: got seen=%0d overlap=%0d want seen=1 overlap=0",
               n_seen, n_both);
    end
    n_vec++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL t4_word_count: got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL t4_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midword();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    reset = 1'b0;
    #1;
    n_vec++;
    if (active !== 1'b0 || data_out !== 8'h00 || valid_out !== 1'b0 ||
        comma_count !== 4'd0) begin
      n_err++;
      $display("FAIL t5_async_reset: got act=%b data=%h v=%b cc=%0d want 0 00 0 0",
               active, data_out, valid_out, comma_count);
    end
    @(negedge clk_8f);
    reset = 1'b1;
    clear_obs();
    repeat (3) send_word(8'hBC);
    n_vec++;
    if (active !== 1'b0) begin
      n_err++;
      $display("FAIL t5_early_relock: got active=%b want 0", active);
    end
    send_word(8'hBC);
    n_vec++;
    if (active !== 1'b1 || n_valid !== 0) begin
      n_err++;
      $display("FAIL t5_relock: got act=%b pulses=%0d want act=1 pulses=0", active, n_valid);
    end
  endtask

  task automatic test_los();
    clear_obs();
    send_word(8'h01);
    send_word(8'h02);
    send_word(8'h03);
    n_vec++;
    if (n_valid !== 3 || active !== 1'b1) begin
      n_err++;
      $display("FAIL t6_first_three: got pulses=%0d act=%b want pulses=3 act=1",
               n_valid, active);
    end
    send_word(8'h04);
`ifdef LOS_DETECT_EN
    n_vec++;
    if (n_valid !== 3 || active !== 1'b0 || fsm_state_o !== ST_HUNT ||
        comma_count !== 4'd0) begin
      n_err++;
      $display("FAIL t6_los: got pulses=%0d act=%b st=%0d cc=%0d want 3 0 0 0",
               n_valid, active, fsm_state_o, comma_count);
    end
`else
    n_vec++;
    if (n_valid !== 4 || active !== 1'b1 || data_out !== 8'h04) begin
      n_err++;
      $display("FAIL t6_no_los: got pulses=%0d act=%b data=%h want 4 1 04",
               n_valid, active, data_out);
    end
`endif
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_aligned_lock();
    test_offset_lock();
    test_relock();
    test_locked_stream();
    test_reset_midword();
    test_los();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
